decode_queue: RTL and testbench
===============================

Name: decode_queue

Overview:
- Parametrised successor to the combinational instruction-field decoder.
- Buffers fetched instructions in a DEPTH-entry queue between IF and ID, with a valid/ready handshake and pipeline flush.
- Decodes the head entry into MIPS fields, extended immediates, jump target and instruction-class flags.
- Isolates fetch from decode stalls: ID stalls never need to back-propagate combinationally into IF.

Parameters:
- DEPTH, 2, queue entries; power of two, minimum 2.
- PC_W, 32, PC width; minimum 28, since jump_addr uses pc[PC_W-1:PC_W-4].
- XLEN, 32, width of the extended-immediate outputs; minimum 16.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all queued entries (branch or jump redirect)
- in_valid  in  1  IF presents an instruction
- in_ready  out  1  queue can accept this cycle
- in_ir  in  32  instruction word
- in_pc  in  PC_W  PC of in_ir
- out_valid  out  1  head entry is valid
- out_ready  in  1  ID consumes the head this cycle
- out_pc  out  PC_W  PC of head
- op  out  6  ir[31:26]
- rs  out  5  ir[25:21]
- rt  out  5  ir[20:16]
- rd  out  5  ir[15:11]
- shamt  out  5  ir[10:6]
- func  out  6  ir[5:0]
- immediate  out  16  ir[15:0]
- imm_sext  out  XLEN  immediate sign-extended
- imm_zext  out  XLEN  immediate zero-extended
- target  out  26  ir[25:0]
- jump_addr  out  PC_W  {pc_plus4[PC_W-1:PC_W-4], zero-extended {target,2'b00}}
- is_rtype  out  1  op==000000
- is_jump  out  1  op==000010 (j) or 000011 (jal)
- is_branch  out  1  op==000100 (beq) or 000101 (bne)
- is_load  out  1  op==100011 (lw)
- is_store  out  1  op==101011 (sw)
- count  out  $clog2(DEPTH+1)  occupancy

Behaviour:
- Reset:
  - Synchronous, active-high; also applies when asserted mid-operation.
  - Clears wr_ptr, rd_ptr and count to 0; storage contents are don't-care.
  - After reset: out_valid=0, in_ready=1, count=0, all decoded outputs 0.
- Handshake:
  - Push when in_valid & in_ready.
  - Pop when out_valid & out_ready.
  - in_ready = (count != DEPTH), registered-state only. There is no same-cycle pass-through of a pop when full.
  - out_valid = (count != 0).
- Latency: an entry accepted at edge N is at the head, with out_valid=1, after edge N when the queue was empty. Minimum latency is 1 cycle.
- Simultaneous push and pop with 0<count<DEPTH: count is unchanged; both pointers advance.
- Pointers: wrap modulo DEPTH. Pop while empty and push while full are ignored; the bench must see no pointer or count change.
- Flush:
  - Synchronous; takes effect at the next edge.
  - Same effect as reset on pointers and count.
  - Takes priority over a push or pop in the same cycle. An instruction offered in the flush cycle is dropped even if in_ready=1.
  - out_valid=0 in the cycle after flush.
- Decode:
  - Combinational from the head entry.
  - When out_valid=0, every field, flag, out_pc, imm_* and jump_addr output is forced to 0, so IF/ID bubbles are clean NOPs.
- Arithmetic:
  - pc_plus4 = out_pc + 4, modulo 2^PC_W.
  - jump_addr = {pc_plus4[PC_W-1:PC_W-4], target, 2'b00} truncated/zero-extended to PC_W.
  - imm_sext replicates immediate[15] into the upper XLEN-16 bits.
- Class flags: mutually exclusive by construction. All flags are 0 for unlisted opcodes.

Decomposition:
- Package decode_pkg:
  - Opcode constants OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_LW, OP_SW.
  - Field-position localparams.
  - Packed struct decoded_t for the field bundle.
  - Function sext16.
- Sub-module ir_fifo: generic DEPTH x (32+PC_W) synchronous FIFO with flush, count, in_ready/out_valid.
- decode_queue wraps ir_fifo and adds the combinational field/flag decode.

Test Plan:
- Reset, then push in_ir=0x8C220004 (lw $2,4($1)) at in_pc=0x00400000 with out_ready=0 → next cycle: out_valid=1, op=0x23, rs=1, rt=2, imm_sext=0x00000004, is_load=1, count=1.
- Push 0x1022FFFE (beq) → imm_sext=0xFFFFFFFE, imm_zext=0x0000FFFE, is_branch=1.
- Push 0x0810000A (j) at pc 0x00400008 → jump_addr=0x00400028, is_jump=1.
- Fill to DEPTH=2 with out_ready=0 → in_ready=0, count=2. A third in_valid is not accepted. Then out_ready=1 for one cycle → count=1, head becomes the second entry, in_ready=1.
- Full queue, assert flush together with in_valid=1 and out_ready=1 → next cycle: count=0, out_valid=0, all outputs 0, the offered word is never seen.
- Continuous push and pop for 10 cycles at DEPTH=4 → in-order output with PCs 0x0,0x4,…; count stays 1; pointer wrap leaves order intact.
- rst asserted mid-stream with count=3 → next cycle: count=0, in_ready=1, out_valid=0.

Source files
------------

// File: rtl/decode_pkg.sv
// ----------------------------------------------------------------------------
// decode_pkg
// Shared definitions for the decode queue: MIPS opcode constants, instruction
// field positions, the decoded field bundle and the immediate sign-extender.
// ----------------------------------------------------------------------------
package decode_pkg;

   localparam int unsigned IR_W      = 32;
   localparam int unsigned OP_W      = 6;
   localparam int unsigned REG_W     = 5;
   localparam int unsigned FUNC_W    = 6;
   localparam int unsigned IMM_W     = 16;
   localparam int unsigned TGT_W     = 26;

   localparam int unsigned OP_LSB    = 26;
   localparam int unsigned RS_LSB    = 21;
   localparam int unsigned RT_LSB    = 16;
   localparam int unsigned RD_LSB    = 11;
   localparam int unsigned SHAMT_LSB = 6;
   localparam int unsigned FUNC_LSB  = 0;
   localparam int unsigned IMM_LSB   = 0;
   localparam int unsigned TGT_LSB   = 0;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_J     = 6'b000010;
   localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

   // Widest extended immediate supported; callers truncate to their XLEN.
   localparam int unsigned SEXT_W = 64;

   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic [REG_W-1:0]  rs;
      logic [REG_W-1:0]  rt;
      logic [REG_W-1:0]  rd;
      logic [REG_W-1:0]  shamt;
      logic [FUNC_W-1:0] func;
      logic [IMM_W-1:0]  immediate;
      logic [TGT_W-1:0]  target;
   } decoded_t;

   function automatic logic [SEXT_W-1:0] sext16(input logic [IMM_W-1:0] imm);
      return {{(SEXT_W-IMM_W){imm[IMM_W-1]}}, imm};
   endfunction

   // Slice an instruction word into its (overlapping) MIPS fields.
   function automatic decoded_t split_ir(input logic [IR_W-1:0] ir);
      decoded_t d;
      d.op        = ir[OP_LSB    +: OP_W];
      d.rs        = ir[RS_LSB    +: REG_W];
      d.rt        = ir[RT_LSB    +: REG_W];
      d.rd        = ir[RD_LSB    +: REG_W];
      d.shamt     = ir[SHAMT_LSB +: REG_W];
      d.func      = ir[FUNC_LSB  +: FUNC_W];
      d.immediate = ir[IMM_LSB   +: IMM_W];
      d.target    = ir[TGT_LSB   +: TGT_W];
      return d;
   endfunction

endpackage

// File: rtl/ir_fifo.sv
// ----------------------------------------------------------------------------
// ir_fifo
// Generic DEPTH x W synchronous FIFO with flush and occupancy count.
// Ports: clk, rst (sync, active-high), flush (sync clear), in_valid/in_ready/
//        in_data (push side), out_valid/out_ready/out_data (pop side), count.
// in_ready/out_valid depend on registered occupancy only. DEPTH is a power of
// two so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module ir_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned W     = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [W-1:0]               in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [W-1:0]               out_data,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push;
   logic          pop;

   assign in_ready  = (count != CW'(DEPTH));
   assign out_valid = (count != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign out_data  = mem[rd_ptr];

   // Pointer and occupancy update; flush clears exactly like reset.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
      end
   end

   // Storage is not reset; entries are only observable once counted.
   always_ff @(posedge clk) begin
      if (push && !flush && !rst) mem[wr_ptr] <= in_data;
   end

endmodule

// File: rtl/decode_queue.sv
// ----------------------------------------------------------------------------
// decode_queue
// IF/ID instruction queue with combinational MIPS decode of the head entry.
// Ports: clk, rst (sync, active-high), flush; in_valid/in_ready/in_ir/in_pc
//        from fetch; out_valid/out_ready/out_pc to decode; decoded fields
//        (op, rs, rt, rd, shamt, func, immediate, target), extended
//        immediates, jump_addr, class flags and occupancy count.
// All decoded outputs read 0 while the queue is empty (clean NOP bubble).
// XLEN is supported up to 64.
// ----------------------------------------------------------------------------
module decode_queue
   import decode_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned PC_W  = 32,
   parameter int unsigned XLEN  = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [31:0]                in_ir,
   input  logic [PC_W-1:0]            in_pc,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [PC_W-1:0]            out_pc,
   output logic [5:0]                 op,
   output logic [4:0]                 rs,
   output logic [4:0]                 rt,
   output logic [4:0]                 rd,
   output logic [4:0]                 shamt,
   output logic [5:0]                 func,
   output logic [15:0]                immediate,
   output logic [XLEN-1:0]            imm_sext,
   output logic [XLEN-1:0]            imm_zext,
   output logic [25:0]                target,
   output logic [PC_W-1:0]            jump_addr,
   output logic                       is_rtype,
   output logic                       is_jump,
   output logic                       is_branch,
   output logic                       is_load,
   output logic                       is_store,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned ENT_W = IR_W + PC_W;

   logic [ENT_W-1:0] head;
   logic [IR_W-1:0]  ir;
   logic [3:0]       pc_hi;
   decoded_t         f;

   ir_fifo #(
      .DEPTH (DEPTH),
      .W     (ENT_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   ({in_ir, in_pc}),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (head),
      .count     (count)
   );

   // Mask the head so an empty queue decodes as all-zero.
   always_comb begin
      ir     = '0;
      out_pc = '0;
      if (out_valid) begin
         ir     = head[PC_W +: IR_W];
         out_pc = head[0 +: PC_W];
      end
   end

   assign f = split_ir(ir);

   assign op        = f.op;
   assign rs        = f.rs;
   assign rt        = f.rt;
   assign rd        = f.rd;
   assign shamt     = f.shamt;
   assign func      = f.func;
   assign immediate = f.immediate;
   assign target    = f.target;
   assign imm_sext  = XLEN'(sext16(f.immediate));
   assign imm_zext  = XLEN'(f.immediate);

   // Region bits come from pc+4 (the delay-slot PC), wrapping modulo 2^PC_W.
   assign pc_hi     = 4'((out_pc + PC_W'(4)) >> (PC_W - 4));
   assign jump_addr = out_valid ? {pc_hi, (PC_W-4)'({f.target, 2'b00})} : '0;

   // Opcodes are distinct constants, so at most one flag can be set.
   assign is_rtype  = out_valid && (f.op == OP_RTYPE);
   assign is_jump   = out_valid && ((f.op == OP_J)   || (f.op == OP_JAL));
   assign is_branch = out_valid && ((f.op == OP_BEQ) || (f.op == OP_BNE));
   assign is_load   = out_valid && (f.op == OP_LW);
   assign is_store  = out_valid && (f.op == OP_SW);

endmodule

// File: tb/tb_decode_queue.sv
// ----------------------------------------------------------------------------
// tb_decode_queue
// Directed bench for decode_queue: a DEPTH=2 instance for decode, handshake
// and flush behaviour, and a DEPTH=4 instance for streaming, wrap and reset.
// ----------------------------------------------------------------------------
module tb_decode_queue;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   // DEPTH=2 instance signals
   logic        flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_ir, in_pc, out_pc, imm_sext, imm_zext, jump_addr;
   logic [5:0]  op, func;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] immediate;
   logic [25:0] target;
   logic        is_rtype, is_jump, is_branch, is_load, is_store;
   logic [1:0]  count;

   // DEPTH=4 instance signals
   logic        flush_4, in_valid_4, in_ready_4, out_valid_4, out_ready_4;
   logic [31:0] in_ir_4, in_pc_4, out_pc_4, imm_sext_4, imm_zext_4, jump_addr_4;
   logic [5:0]  op_4, func_4;
   logic [4:0]  rs_4, rt_4, rd_4, shamt_4;
   logic [15:0] immediate_4;
   logic [25:0] target_4;
   logic        is_rtype_4, is_jump_4, is_branch_4, is_load_4, is_store_4;
   logic [2:0]  count_4;

   decode_queue #(.DEPTH(2), .PC_W(32), .XLEN(32)) u_d2 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_ir(in_ir), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .func(func),
      .immediate(immediate), .imm_sext(imm_sext), .imm_zext(imm_zext),
      .target(target), .jump_addr(jump_addr),
      .is_rtype(is_rtype), .is_jump(is_jump), .is_branch(is_branch),
      .is_load(is_load), .is_store(is_store), .count(count)
   );

   decode_queue #(.DEPTH(4), .PC_W(32), .XLEN(32)) u_d4 (
      .clk(clk), .rst(rst), .flush(flush_4),
      .in_valid(in_valid_4), .in_ready(in_ready_4), .in_ir(in_ir_4), .in_pc(in_pc_4),
      .out_valid(out_valid_4), .out_ready(out_ready_4), .out_pc(out_pc_4),
      .op(op_4), .rs(rs_4), .rt(rt_4), .rd(rd_4), .shamt(shamt_4), .func(func_4),
      .immediate(immediate_4), .imm_sext(imm_sext_4), .imm_zext(imm_zext_4),
      .target(target_4), .jump_addr(jump_addr_4),
      .is_rtype(is_rtype_4), .is_jump(is_jump_4), .is_branch(is_branch_4),
      .is_load(is_load_4), .is_store(is_store_4), .count(count_4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      flush = 1'b0; in_valid = 1'b0; in_ir = '0; in_pc = '0; out_ready = 1'b0;
      flush_4 = 1'b0; in_valid_4 = 1'b0; in_ir_4 = '0; in_pc_4 = '0; out_ready_4 = 1'b0;
      step();
      step();
      rst = 1'b0;

      // Reset state
      check("rst_count",     count, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready",  in_ready, 1);
      check("rst_op",        op, 0);
      check("rst_imm_sext",  imm_sext, 0);
      check("rst_jump_addr", jump_addr, 0);
      check("rst_out_pc",    out_pc, 0);
      check("rst_count_4",   count_4, 0);

      // lw $2,4($1): one-cycle latency to the head
      in_valid = 1'b1; in_ir = 32'h8C220004; in_pc = 32'h00400000;
      step();
      in_valid = 1'b0;
      check("lw_out_valid", out_valid, 1);
      check("lw_op",        op, 6'h23);
      check("lw_rs",        rs, 1);
      check("lw_rt",        rt, 2);
      check("lw_imm_sext",  imm_sext, 32'h00000004);
      check("lw_is_load",   is_load, 1);
      check("lw_is_branch", is_branch, 0);
      check("lw_count",     count, 1);
      check("lw_out_pc",    out_pc, 32'h00400000);

      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("pop_count",     count, 0);
      check("pop_out_valid", out_valid, 0);
      check("pop_is_load",   is_load, 0);

      // beq with negative offset
      in_valid = 1'b1; in_ir = 32'h1022FFFE; in_pc = 32'h00400004;
      step();
      check("beq_immediate", immediate, 16'hFFFE);
      check("beq_imm_sext",  imm_sext, 32'hFFFFFFFE);
      check("beq_imm_zext",  imm_zext, 32'h0000FFFE);
      check("beq_is_branch", is_branch, 1);
      check("beq_is_load",   is_load, 0);

      // j pushed while beq pops: occupancy unchanged
      in_ir = 32'h0810000A; in_pc = 32'h00400008; out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("j_count",     count, 1);
      check("j_out_pc",    out_pc, 32'h00400008);
      check("j_is_jump",   is_jump, 1);
      check("j_target",    target, 26'h010000A);
      check("j_jump_addr", jump_addr, 32'h00400028);

      // Fill to DEPTH with add $3,$1,$2
      in_ir = 32'h00221820; in_pc = 32'h0040000C;
      step();
      check("full_count",    count, 2);
      check("full_in_ready", in_ready, 0);
      check("full_head",     out_pc, 32'h00400008);

      // Push while full is ignored
      in_ir = 32'hAC230008; in_pc = 32'h00400010;
      step();
      in_valid = 1'b0;
      check("ovf_count", count, 2);
      check("ovf_head",  out_pc, 32'h00400008);

      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("drain_count",    count, 1);
      check("drain_in_ready", in_ready, 1);
      check("add_out_pc",     out_pc, 32'h0040000C);
      check("add_is_rtype",   is_rtype, 1);
      check("add_rd",         rd, 3);
      check("add_shamt",      shamt, 0);
      check("add_func",       func, 6'h20);
      check("add_is_jump",    is_jump, 0);

      in_valid = 1'b1; in_ir = 32'hAC230008; in_pc = 32'h00400010;
      step();
      check("refill_count", count, 2);

      // Flush with push and pop on a full queue
      in_ir = 32'h8C000000; in_pc = 32'h00400014; flush = 1'b1; out_ready = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      check("flush_count",     count, 0);
      check("flush_out_valid", out_valid, 0);
      check("flush_in_ready",  in_ready, 1);
      check("flush_out_pc",    out_pc, 0);
      check("flush_op",        op, 0);
      check("flush_imm_sext",  imm_sext, 0);
      check("flush_imm_zext",  imm_zext, 0);
      check("flush_jump_addr", jump_addr, 0);
      check("flush_is_rtype",  is_rtype, 0);
      step();
      check("flush_dropped_count", count, 0);
      check("flush_dropped_valid", out_valid, 0);

      // Jump region taken from pc+4
      in_valid = 1'b1; in_ir = 32'h0BFFFFFF; in_pc = 32'h7FFFFFFC;
      step();
      check("jhi_target",    target, 26'h3FFFFFF);
      check("jhi_jump_addr", jump_addr, 32'h8FFFFFFC);

      // jal at top of address space: pc+4 wraps to 0
      in_ir = 32'h0C000001; in_pc = 32'hFFFFFFFC; out_ready = 1'b1;
      step();
      check("jal_is_jump",   is_jump, 1);
      check("jal_jump_addr", jump_addr, 32'h00000004);
      check("jal_count",     count, 1);

      in_ir = 32'hAC230008; in_pc = 32'h00000100;
      step();
      check("sw_is_store", is_store, 1);
      check("sw_is_load",  is_load, 0);
      check("sw_rt",       rt, 3);
      check("sw_imm_sext", imm_sext, 32'h00000008);

      // lui: unlisted opcode raises no flag
      in_ir = 32'h3C011234; in_pc = 32'h00000104;
      step();
      check("lui_op",    op, 6'h0F);
      check("lui_flags", {is_rtype, is_jump, is_branch, is_load, is_store}, 0);
      check("lui_zext",  imm_zext, 32'h00001234);

      in_ir = 32'h14228000; in_pc = 32'h00000108;
      step();
      in_valid = 1'b0;
      check("bne_is_branch", is_branch, 1);
      check("bne_imm_sext",  imm_sext, 32'hFFFF8000);
      check("bne_imm_zext",  imm_zext, 32'h00008000);

      step();
      out_ready = 1'b0;
      check("end2_count",     count, 0);
      check("end2_out_valid", out_valid, 0);

      // DEPTH=4: pop while empty is ignored
      out_ready_4 = 1'b1;
      step();
      check("d4_empty_pop_count", count_4, 0);

      // Continuous push and pop; head follows in order across pointer wrap
      in_valid_4 = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_pc_4 = 32'(4 * i);
         in_ir_4 = 32'(i);
         step();
         check("d4_stream_count", count_4, 1);
         check("d4_stream_pc",    out_pc_4, 32'(4 * i));
         check("d4_stream_imm",   immediate_4, 16'(i));
      end
      in_valid_4 = 1'b0;
      step();
      out_ready_4 = 1'b0;
      check("d4_drain_count", count_4, 0);

      in_valid_4 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_pc_4 = 32'h100 + 32'(4 * i);
         step();
      end
      check("d4_full_count",    count_4, 4);
      check("d4_full_in_ready", in_ready_4, 0);
      check("d4_full_head",     out_pc_4, 32'h100);

      in_pc_4 = 32'h110;
      step();
      in_valid_4 = 1'b0;
      check("d4_ovf_count", count_4, 4);
      check("d4_ovf_head",  out_pc_4, 32'h100);

      out_ready_4 = 1'b1;
      step();
      out_ready_4 = 1'b0;
      check("d4_pop_count", count_4, 3);
      check("d4_pop_head",  out_pc_4, 32'h104);

      // Reset mid-stream with an offered word
      rst = 1'b1; in_valid_4 = 1'b1; in_pc_4 = 32'h200;
      step();
      rst = 1'b0; in_valid_4 = 1'b0;
      check("d4_rst_count",     count_4, 0);
      check("d4_rst_in_ready",  in_ready_4, 1);
      check("d4_rst_out_valid", out_valid_4, 0);
      check("d4_rst_out_pc",    out_pc_4, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
